// File: rtl/math_pkg.sv
// math_pkg
// Shared constants and types for the binary-to-BCD converter.
//   BCD_W      : binary input width (17-bit adder sum)
//   BCD_DIGITS : number of BCD digits produced
//   bcd_state_e: converter FSM states
//   pow10()    : elaboration-time helper for the digit-count sanity check
package math_pkg;

  localparam int BCD_W      = 17;
  localparam int BCD_DIGITS = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_e;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/math_bcd_digit_adj.sv
// math_bcd_digit_adj
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more,
// so that the following left shift carries correctly into the next digit.
//   digit_i : 4-bit scratch digit before the shift
//   digit_o : corrected digit
module math_bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) digit_o = digit_i + 4'd3;
  end

endmodule

// File: rtl/math_bin2bcd_17bit.sv
// math_bin2bcd_17bit
// Sequential double-dabble binary-to-BCD converter, one adjust-then-shift
// step per clock.
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset
//   start    : conversion request, sampled only in IDLE
//   bin      : unsigned binary value, captured with start
//   busy     : conversion in progress (SHIFT or DONE)
//   done     : one-cycle pulse while bcd holds a fresh result
//   bcd      : packed BCD result, digit 0 in bcd[3:0]
//   digit_en : per-digit display enable
// Build option: MATH_BCD_LZB_EN enables leading-zero blanking on digit_en;
// otherwise digit_en is constant all ones.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | W adjust-then-shift steps, count runs W..1
// DONE  | result visible on bcd, done asserted, back to IDLE
module math_bin2bcd_17bit
  import math_pkg::*;
#(
  parameter int W = BCD_W,
  parameter int D = BCD_DIGITS
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   bin,
  output logic           busy,
  output logic           done,
  output logic [4*D-1:0] bcd,
  output logic [D-1:0]   digit_en
);

  localparam int CW = $clog2(W + 1);

  if (pow10(D) <= ((64'd1 << W) - 64'd1)) begin : g_bad_digits
    $error("math_bin2bcd_17bit: D digits cannot hold 2^W-1");
  end

  bcd_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   bin_q, bin_d;
  logic [4*D-1:0] dig_q, dig_d;
  logic [4*D-1:0] bcd_q, bcd_d;
  logic [4*D-1:0] dig_adj;
  logic [4*D+W-1:0] shifted;

  for (genvar g = 0; g < D; g++) begin : g_adj
    math_bcd_digit_adj u_adj (
      .digit_i (dig_q[4*g +: 4]),
      .digit_o (dig_adj[4*g +: 4])
    );
  end

  assign shifted = {dig_adj, bin_q} << 1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    dig_d   = dig_q;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = bin;
          dig_d   = '0;
          cnt_d   = CW'(W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        dig_d = shifted[4*D+W-1:W];
        bin_d = shifted[W-1:0];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          // Result is loaded on the edge entering DONE so that bcd already
          // holds it during the done cycle.
          bcd_d   = shifted[4*D+W-1:W];
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      dig_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      dig_q   <= dig_d;
      bcd_q   <= bcd_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign bcd  = bcd_q;

`ifdef MATH_BCD_LZB_EN
  logic [D-1:0] en_q, en_d;

  // A digit is shown if it or any more significant digit is nonzero;
  // the units digit is always shown.
  always_comb begin
    en_d = en_q;
    if (state_q == SHIFT && state_d == DONE) begin
      en_d[D-1] = (bcd_d[4*(D-1) +: 4] != 4'd0);
      for (int i = D - 2; i >= 0; i--)
        en_d[i] = en_d[i+1] | (bcd_d[4*i +: 4] != 4'd0);
      en_d[0] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) en_q <= D'(1);
    else        en_q <= en_d;
  end

  assign digit_en = en_q;
`else
  assign digit_en = '1;
`endif

endmodule

// File: tb/tb_math_bin2bcd_17bit.sv
module tb_math_bin2bcd_17bit;

  localparam int W   = 17;
  localparam int D   = 6;
  localparam int LAT = 18;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   bin = '0;
  logic           busy;
  logic           done;
  logic [4*D-1:0] bcd;
  logic [D-1:0]   digit_en;

  math_bin2bcd_17bit #(.W(W), .D(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .digit_en (digit_en)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit abort_run = 1'b0;

  typedef struct {
    int unsigned val;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  // Decimal reference: digit i = floor(v / 10^i) mod 10.
  function automatic logic [4*D-1:0] ref_bcd(input int unsigned v);
    logic [4*D-1:0] r;
    int unsigned p;
    p = 1;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [D-1:0] ref_en(input int unsigned v);
    logic [D-1:0] e;
    int unsigned p;
    e = '1;
`ifdef MATH_BCD_LZB_EN
    p = 1;
    for (int i = 0; i < D; i++) begin
      e[i] = (i == 0) || (v >= p);
      p = p * 10;
    end
`else
    p = 0;
`endif
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor / scoreboard
  int busy_run = 0;
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", {63'd0, done}, 64'd0);
      end else begin
        exp_t e;
        bit bad_digit;
        e = exp_q.pop_front();
        bad_digit = 1'b0;
        for (int i = 0; i < D; i++)
          if (bcd[4*i +: 4] > 4'd9) bad_digit = 1'b1;
        check("bcd", 64'(bcd), 64'(ref_bcd(e.val)));
        check("digit_en", 64'(digit_en), 64'(ref_en(e.val)));
        check("digit_range", {63'd0, bad_digit}, 64'd0);
        check("latency", 64'(cyc), 64'(e.due));
      end
    end
    if (busy) begin
      busy_run++;
    end else if (busy_run != 0) begin
      if (!abort_run) check("busy_len", 64'(busy_run), 64'(LAT));
      abort_run = 1'b0;
      busy_run = 0;
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("done_timeout", {63'd0, done}, 64'd1);
  endtask

  task automatic issue(input int unsigned v);
    exp_t e;
    wait_idle();
    start = 1'b1;
    bin = W'(v);
    e.val = v;
    e.due = cyc + LAT;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    bin = W'($urandom);
  endtask

  initial begin
    #(90000 * 10);
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_bcd", 64'(bcd), 64'd0);
    check("rst_digit_en", 64'(digit_en), 64'(ref_en(0)));
    rst_n = 1'b1;
    @(negedge clk);

    issue(0);
    issue(131071);
    issue(99999);
    issue(1);

    // start during SHIFT and during DONE must be ignored
    issue(1234);
    repeat (3) @(negedge clk);
    start = 1'b1;
    bin = W'(5678);
    @(negedge clk);
    start = 1'b0;
    wait_done();
    start = 1'b1;
    bin = W'(42);
    @(negedge clk);
    start = 1'b0;

    // reset mid-conversion aborts without a done pulse
    issue(4095);
    repeat (7) @(negedge clk);
    abort_run = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    check("abort_bcd", 64'(bcd), 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    repeat (25) @(negedge clk);
    issue(7);

    for (int k = 0; k < 3000; k++) begin
      issue($urandom_range(0, 131071));
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("pending_results", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
